// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported synchronous RAM between the instruction-fetch port
// and the data-access port. Grants at most one access per cycle. Read data
// returns one cycle after the grant and goes only to the port that issued it.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_req/i_addr               fetch request (read only)
//   i_gnt/i_stall              fetch granted this cycle / waiting for a grant
//   i_rvalid/i_rdata           fetch read return
//   d_req/d_we/d_addr/d_wdata  data request (read or write)
//   d_gnt/d_stall              data granted this cycle / waiting for a grant
//   d_rvalid/d_rdata           data read return
//   m_en/m_we/m_addr/m_wdata   memory command
//   m_rdata                    memory read data, one cycle after a read command
//
// Build option:
//   MEM_ARB_DATA_PRIORITY_EN   defined: the data port always wins a conflict.
//                              undefined: round-robin between the two ports.

module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_stall,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_stall,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  // last_win: 0 = fetch won the most recent grant, 1 = data won it.
  logic last_win_q, last_win_d;
  // Read in flight: valid bit and owner (0 = fetch, 1 = data).
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;

  // Arbitration, same cycle. Grants are forced low while reset is high.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
`ifdef MEM_ARB_DATA_PRIORITY_EN
      // last_win is still tracked below but plays no part in the decision.
      d_gnt = d_req;
      i_gnt = i_req & ~d_req;
`else
      if (i_req && d_req) begin
        // Grant whichever port did not win last time.
        i_gnt = last_win_q;
        d_gnt = ~last_win_q;
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
`endif
    end
  end

  assign i_stall = i_req & ~i_gnt;
  assign d_stall = d_req & ~d_gnt;

  // Memory command.
  always_comb begin
    m_en    = i_gnt | d_gnt;
    m_we    = d_gnt & d_we;
    m_addr  = '0;
    m_wdata = '0;
    if (i_gnt) begin
      m_addr = i_addr;
    end else if (d_gnt) begin
      m_addr = d_addr;
    end
    if (i_gnt || d_gnt) begin
      m_wdata = d_wdata;
    end
  end

  // Next-state logic.
  always_comb begin
    last_win_d = last_win_q;
    if (i_gnt) begin
      last_win_d = 1'b0;
    end else if (d_gnt) begin
      last_win_d = 1'b1;
    end
    rd_pend_d  = i_gnt | (d_gnt & ~d_we);
    rd_owner_d = d_gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_win_q <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      last_win_q <= last_win_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Read return. A read granted just before reset must not surface in the
  // reset cycle, so the pending flag is masked by reset as well.
  always_comb begin
    i_rvalid = rd_pend_q & ~rd_owner_q & ~reset;
    d_rvalid = rd_pend_q & rd_owner_q & ~reset;
    i_rdata  = i_rvalid ? m_rdata : '0;
    d_rdata  = d_rvalid ? m_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

`ifdef MEM_ARB_DATA_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [7:0]  i_addr;
  logic        i_gnt, i_stall, i_rvalid;
  logic [15:0] i_rdata;
  logic        d_req, d_we;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt, d_stall, d_rvalid;
  logic [15:0] d_rdata;
  logic        m_en, m_we;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_stall(i_stall),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_stall(d_stall), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, preloaded with 0xA000 + address.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr] = m_wdata;
    if (m_en && !m_we) m_rdata <= mem[m_addr];
  end

  // Bench-side copy of what memory should contain.
  logic [15:0] ref_mem [256];

  typedef struct packed {
    logic        v;
    logic        owner;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven; checks this cycle's
  // grant/memory command and the read return predicted one cycle earlier,
  // then records the read expected from this cycle's grant.
  task automatic step(input logic eig, input logic edg);
    exp_t e;
    exp_t n;
    logic ee;
    #1;
    ee = eig | edg;
    chk("i_gnt",   i_gnt,   eig);
    chk("d_gnt",   d_gnt,   edg);
    chk("i_stall", i_stall, i_req & ~eig);
    chk("d_stall", d_stall, d_req & ~edg);
    chk("m_en",    m_en,    ee);
    chk("m_we",    m_we,    edg & d_we);
    chk("m_addr",  m_addr,  eig ? i_addr : (edg ? d_addr : 8'h00));
    chk("m_wdata", m_wdata, ee ? d_wdata : 16'h0000);
    e = '0;
    if (reset) exp_q.delete();
    else if (exp_q.size() != 0) e = exp_q.pop_front();
    chk("i_rvalid", i_rvalid, e.v & ~e.owner);
    chk("d_rvalid", d_rvalid, e.v & e.owner);
    chk("i_rdata",  i_rdata,  (e.v & ~e.owner) ? e.data : 16'h0000);
    chk("d_rdata",  d_rdata,  (e.v & e.owner) ? e.data : 16'h0000);
    if (!reset) begin
      n.v     = eig | (edg & ~d_we);
      n.owner = edg;
      n.data  = eig ? ref_mem[i_addr] : ref_mem[d_addr];
      exp_q.push_back(n);
      if (edg && d_we) ref_mem[d_addr] = d_wdata;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] fa;
    logic [7:0] da;
    logic       eig;
    for (int a = 0; a < 256; a++) begin
      mem[a]     = 16'hA000 + 16'(a);
      ref_mem[a] = 16'hA000 + 16'(a);
    end
    reset   = 1'b1;
    i_req   = 1'b1;
    i_addr  = 8'h05;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 8'h06;
    d_wdata = 16'h0000;
    @(negedge clk);

    // Reset held two cycles with both ports requesting.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Both requesting for six cycles.
    reset = 1'b0;
    fa = 8'h20;
    da = 8'h30;
    for (int k = 0; k < 6; k++) begin
      i_addr = fa;
      d_addr = da;
      eig = PRIO ? 1'b0 : ((k % 2) == 0);
      step(eig, ~eig);
      if (eig) fa++;
      else da++;
    end
    // Data drops out: fetch granted in the same cycle.
    d_req  = 1'b0;
    i_addr = fa;
    step(1'b1, 1'b0);
    i_req = 1'b0;
    step(1'b0, 1'b0);

    // Fetch-only stream.
    i_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_addr = 8'(k);
      step(1'b1, 1'b0);
    end
    i_req = 1'b0;
    step(1'b0, 1'b0);

    // Data write, then read back the same address.
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 8'h40;
    d_wdata = 16'h1234;
    step(1'b0, 1'b1);
    d_we    = 1'b0;
    d_wdata = 16'h0000;
    step(1'b0, 1'b1);
    d_req = 1'b0;
    step(1'b0, 1'b0);
    chk("ram_0x40", ref_mem[8'h40], 16'h1234);

    // Fetch read granted, reset the following cycle: its data is dropped.
    i_req  = 1'b1;
    i_addr = 8'h10;
    step(1'b1, 1'b0);
    i_req = 1'b0;
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Conflict right after reset, with a data write in the mix.
    i_req   = 1'b1;
    i_addr  = 8'h50;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 8'h51;
    d_wdata = 16'hBEEF;
    if (PRIO) begin
      step(1'b0, 1'b1);
      d_req = 1'b0;
      d_we  = 1'b0;
      step(1'b1, 1'b0);
    end else begin
      step(1'b1, 1'b0);
      i_addr = 8'h51;
      step(1'b0, 1'b1);
      d_req = 1'b0;
      d_we  = 1'b0;
      step(1'b1, 1'b0);
    end
    i_req = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between the processor's instruction-fetch requester and its data-access requester, giving a von Neumann memory system.
- Sits between the cpu and a unified program/data RAM.
- Grants at most one access per cycle. Read data returns one cycle later, tagged to the requester that issued it.
- Per-requester stall outputs let the cpu freeze PC and register writes while it waits for a grant.

Parameters:
- ADDR_W, 8, memory address width (matches the 8-bit PC and ALUResult).
- DATA_W, 16, memory word width. Data-side traffic uses full words.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  instruction fetch request (read only)
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch granted this cycle
- i_stall  out  1  i_req & ~i_gnt
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  data access request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data access granted this cycle
- d_stall  out  1  d_req & ~d_gnt
- d_rvalid  out  1  data read valid
- d_rdata  out  DATA_W  data read data
- m_en  out  1  memory enable
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid one cycle after m_en & ~m_we

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (port names clk, reset).
- State:
  - last_win (1 bit; 0 = fetch, 1 = data).
  - rd_pend (valid bit plus owner bit) tracks the read in flight.
- Reset:
  - last_win = 1, so fetch wins the first conflict.
  - rd_pend cleared.
  - While reset is high, all gnt/rvalid/m_en/m_we = 0, regardless of requests.
- Arbitration: combinational, same cycle.
  - Only one requester active: it is granted.
  - Both active: round-robin; the requester that did not win last_win is granted.
  - last_win updates on every grant. With no request, last_win holds.
- Memory drive on a grant:
  - m_en = 1; m_addr = the winner's address.
  - m_we = d_we & d_gnt; m_wdata = d_wdata.
  - With no grant: m_en = 0, m_we = 0, m_addr/m_wdata = 0.
- Read return:
  - A granted read sets rd_pend = {1, owner}.
  - Next cycle the owner's rvalid = 1 and its rdata = m_rdata.
  - The non-owner's rdata = 0.
  - Granted writes produce no rvalid.
- Throughput: one access per cycle. Back-to-back reads overlap: issue in cycle N, return in N+1 while a new read issues in N+1.
- Requester rule: each requester holds req/addr/we/wdata stable until granted. The arbiter does not latch requests.
- Reset mid-operation: a read granted in the cycle before reset asserts is dropped. No rvalid appears in or after the reset cycle.
- Write followed by read of the same address on consecutive cycles: the read returns the new data (memory is write-first or the access is sequential).
- Every input combination is legal; requests are never dropped, only delayed.

Optional Feature:
- Macro: MEM_ARB_DATA_PRIORITY_EN.
- Defined: fixed priority. On conflict the data port always wins, so a load/store is never stalled. last_win is still maintained but ignored. Fetch can starve while d_req stays high.
- Undefined: round-robin as above. Worst-case wait for either requester is 1 cycle.

Test Plan:
- Reset held 2 cycles with i_req = d_req = 1: all gnt/rvalid/m_en = 0. First cycle after reset grants fetch (i_gnt = 1, d_stall = 1); second cycle grants data.
- Fetch-only stream, i_addr = 0x00, 0x01, 0x02 on consecutive cycles, memory holds 0xA000+addr: i_gnt = 1 every cycle, i_rvalid each following cycle with 0xA000, 0xA001, 0xA002, d_rvalid = 0.
- Both requesting for 6 cycles, d_we = 0: grants alternate F, D, F, D, F, D. Each rvalid appears on the matching port one cycle later.
- Data write d_addr = 0x40, d_wdata = 0x1234, then data read of 0x40: m_we = 1 for one cycle, no rvalid for the write; the read returns d_rdata = 0x1234.
- Fetch read of 0x10 granted, reset asserted the next cycle: i_rvalid stays 0 throughout and after reset.
- With MEM_ARB_DATA_PRIORITY_EN, both requesting for 4 cycles: d_gnt = 1 all 4 cycles, i_stall = 1 all 4. Dropping d_req grants fetch the same cycle.
